vec_insn_encoder: RTL and testbench

Assembles 32-bit RVV instructions (OP-V ALU, OP-V vsetvl*, LOAD-FP/STORE-FP vector memory) from field-level requests and buffers them for issue. It sits on the scalar-to-vector path as the counterpart of the instruction field decoder: it packs the same fields at the same bit positions. It queues encoded words in a small FIFO and hands them to the vector core over a valid/ready interface.

---
 rtl/vec_insn_encoder.sv | 173 +++++++++++++++++
 tb/tb_vec_insn_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_insn_encoder.sv
// vec_insn_encoder: packs RVV instruction fields (OP-V ALU, vsetvl*, vector
// load/store) into 32-bit words and queues them in a small FIFO for issue to
// the vector core over a valid/ready interface.
module vec_insn_encoder #(
    parameter int unsigned INSN_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            kind,
    input  logic [6:0]            opcode_mjr,
    input  logic [2:0]            opcode_mnr,
    input  logic [4:0]            dest,
    input  logic [4:0]            src_1,
    input  logic [4:0]            src_2,
    input  logic                  vm,
    input  logic [5:0]            funct6,
    input  logic [2:0]            width,
    input  logic [1:0]            mop,
    input  logic                  mew,
    input  logic [2:0]            nf,
    input  logic [10:0]           vtype_11,
    input  logic [9:0]            vtype_10,
    input  logic [1:0]            cfg_type,
    // issue side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INSN_WIDTH-1:0] insn_out,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  issued_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        KindAlu = 2'd0,
        KindCfg = 2'd1,
        KindMem = 2'd2,
        KindIll = 2'd3
    } kind_e;

    kind_e kind_sel;
    assign kind_sel = kind_e'(kind);

    // ------------------------------------------------------------------
    // Encoding
    // ------------------------------------------------------------------
    logic [31:0]           alu_word;
    logic [31:0]           cfg_word;
    logic [31:0]           mem_word;
    logic [31:0]           enc_word;
    logic [INSN_WIDTH-1:0] wr_word;

    // Per-format word assembly; low fields are shared across all formats.
    always_comb begin
        alu_word = {funct6, vm, src_2, src_1, opcode_mnr, dest, opcode_mjr};
        mem_word = {nf, mew, mop, vm, src_2, src_1, width, dest, opcode_mjr};

        cfg_word        = '0;
        cfg_word[6:0]   = opcode_mjr;
        cfg_word[11:7]  = dest;
        cfg_word[14:12] = 3'b111;
        cfg_word[19:15] = src_1;
        if (!cfg_type[1]) begin
            // vsetvli: 11-bit vtype immediate, top bit clear
            cfg_word[31]    = 1'b0;
            cfg_word[30:20] = vtype_11;
        end else if (cfg_type[0]) begin
            // vsetivli: 10-bit vtype immediate, uimm AVL lives in src_1
            cfg_word[31:30] = 2'b11;
            cfg_word[29:20] = vtype_10;
        end else begin
            // vsetvl: vtype comes from register src_2
            cfg_word[31:25] = 7'b1000000;
            cfg_word[24:20] = src_2;
        end
    end

    // Select the encoded word by request kind.
    always_comb begin
        enc_word = '0;
        unique case (kind_sel)
            KindAlu: enc_word = alu_word;
            KindCfg: enc_word = cfg_word;
            KindMem: enc_word = mem_word;
            KindIll: enc_word = '0;
            default: enc_word = '0;
        endcase
    end

    assign wr_word = INSN_WIDTH'(enc_word);

    // ------------------------------------------------------------------
    // FIFO and handshakes
    // ------------------------------------------------------------------
    logic [INSN_WIDTH-1:0] mem_q [DEPTH];
    logic [INSN_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d;
    logic                  err_q, err_d;

    logic accept;
    logic issue;
    logic push;
    logic pop;

    // Handshake qualifiers; illegal requests complete the handshake but never enter the FIFO.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        accept    = in_valid & in_ready;
        issue     = out_valid & out_ready;
        push      = accept & (kind_sel != KindIll);
        pop       = issue;
    end

    // Next-state for storage, pointers, occupancy, counter and error pulse.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wptr_q] = wr_word;
        end

        wptr_d = push ? (wptr_q + PTR_W'(1)) : wptr_q;
        rptr_d = pop  ? (rptr_q + PTR_W'(1)) : rptr_q;

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        issued_d = pop ? (issued_q + CNT_WIDTH'(1)) : issued_q;
        err_d    = accept & (kind_sel == KindIll);
    end

    // State registers with synchronous reset; reset discards all queued words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
            err_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    // Head word is gated so the output reads zero whenever the FIFO is empty.
    always_comb begin
        insn_out   = out_valid ? mem_q[rptr_q] : '0;
        err        = err_q;
        issued_cnt = issued_q;
    end

endmodule

// File: tb/tb_vec_insn_encoder.sv
// Self-checking bench for vec_insn_encoder: table-driven encodings plus
// hand-written back-pressure, illegal, wrap and reset sequences, all checked
// through a scoreboard queue by a per-cycle monitor.
module tb_vec_insn_encoder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  kind;
    logic [6:0]  opcode_mjr;
    logic [2:0]  opcode_mnr;
    logic [4:0]  dest, src_1, src_2;
    logic        vm;
    logic [5:0]  funct6;
    logic [2:0]  width;
    logic [1:0]  mop;
    logic        mew;
    logic [2:0]  nf;
    logic [10:0] vtype_11;
    logic [9:0]  vtype_10;
    logic [1:0]  cfg_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] insn_out;
    logic        err;
    logic [CW-1:0] issued_cnt;

    vec_insn_encoder #(
        .INSN_WIDTH(32),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .opcode_mjr(opcode_mjr),
        .opcode_mnr(opcode_mnr),
        .dest      (dest),
        .src_1     (src_1),
        .src_2     (src_2),
        .vm        (vm),
        .funct6    (funct6),
        .width     (width),
        .mop       (mop),
        .mew       (mew),
        .nf        (nf),
        .vtype_11  (vtype_11),
        .vtype_10  (vtype_10),
        .cfg_type  (cfg_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .insn_out  (insn_out),
        .err       (err),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [6:0]  mjr;
        logic [2:0]  mnr;
        logic [4:0]  dest;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        vm;
        logic [5:0]  f6;
        logic [2:0]  width;
        logic [1:0]  mop;
        logic        mew;
        logic [2:0]  nf;
        logic [10:0] vt11;
        logic [9:0]  vt10;
        logic [1:0]  ct;
        logic [31:0] exp;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]   sb_q[$];
    logic [31:0]   exp_word;
    logic [CW-1:0] cnt_m;
    logic          err_m;
    logic          mon_en;
    int            err_seen;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic vec_t mk(logic [1:0] k, logic [6:0] mjr, logic [2:0] mnr, logic [4:0] d,
                                logic [4:0] s1, logic [4:0] s2, logic v, logic [5:0] f6,
                                logic [2:0] w, logic [1:0] mo, logic me, logic [2:0] n,
                                logic [10:0] v11, logic [9:0] v10, logic [1:0] ct,
                                logic [31:0] e);
        vec_t r;
        r.kind = k;  r.mjr = mjr; r.mnr = mnr; r.dest = d; r.s1 = s1; r.s2 = s2;
        r.vm = v;    r.f6 = f6;   r.width = w; r.mop = mo; r.mew = me; r.nf = n;
        r.vt11 = v11; r.vt10 = v10; r.ct = ct; r.exp = e;
        return r;
    endfunction

    // Reference encoding written straight from the field layouts.
    function automatic logic [31:0] model_enc(vec_t r);
        case (r.kind)
            2'd0: return {r.f6, r.vm, r.s2, r.s1, r.mnr, r.dest, r.mjr};
            2'd1: begin
                if (!r.ct[1]) return {1'b0, r.vt11, r.s1, 3'b111, r.dest, r.mjr};
                else if (r.ct[0]) return {2'b11, r.vt10, r.s1, 3'b111, r.dest, r.mjr};
                else return {7'b1000000, r.s2, r.s1, 3'b111, r.dest, r.mjr};
            end
            2'd2: return {r.nf, r.mew, r.mop, r.vm, r.s2, r.s1, r.width, r.dest, r.mjr};
            default: return 32'h0;
        endcase
    endfunction

    function automatic vec_t rand_req(logic [1:0] k);
        vec_t r;
        r = mk(k, 7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom), 6'($urandom), 3'($urandom), 2'($urandom), 1'($urandom),
               3'($urandom), 11'($urandom), 10'($urandom), 2'($urandom), 32'h0);
        r.exp = model_enc(r);
        return r;
    endfunction

    // Per-cycle monitor: compare outputs against the model, then advance the model.
    always @(negedge clk) begin
        bit acc;
        if (mon_en) begin
            chk("issued_cnt", 32'(issued_cnt), 32'(cnt_m));
            chk("err", 32'(err), 32'(err_m));
            chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(sb_q.size() != DEPTH));
            chk("insn_out", insn_out, (sb_q.size() != 0) ? sb_q[0] : 32'h0);
            if (err === 1'b1) err_seen++;
        end
        if (rst) begin
            sb_q.delete();
            cnt_m = '0;
            err_m = 1'b0;
        end else begin
            acc   = in_valid && (sb_q.size() != DEPTH);
            err_m = acc && (kind == 2'd3);
            if (out_ready && sb_q.size() != 0) begin
                void'(sb_q.pop_front());
                cnt_m = cnt_m + 1'b1;
            end
            if (acc && kind != 2'd3) sb_q.push_back(exp_word);
        end
    end

    task automatic drive(input vec_t r);
        kind = r.kind; opcode_mjr = r.mjr; opcode_mnr = r.mnr; dest = r.dest;
        src_1 = r.s1; src_2 = r.s2; vm = r.vm; funct6 = r.f6; width = r.width;
        mop = r.mop; mew = r.mew; nf = r.nf; vtype_11 = r.vt11; vtype_10 = r.vt10;
        cfg_type = r.ct; exp_word = r.exp;
    endtask

    // Present one request and hold it until it is accepted (bounded).
    task automatic send(input vec_t r);
        bit ok = 1'b0;
        int n  = 0;
        drive(r);
        in_valid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t tbl[8];

    initial begin
        // Table: fields outside each format carry junk to prove they are ignored.
        tbl[0] = mk(2'd0, 7'h57, 3'd0, 5'd1, 5'd2, 5'd3, 1'b1, 6'h00, 3'd5, 2'd2, 1'b1, 3'd7,
                    11'h7FF, 10'h3FF, 2'd3, 32'h023100D7);
        tbl[1] = mk(2'd1, 7'h57, 3'd2, 5'd5, 5'd10, 5'd31, 1'b1, 6'h3F, 3'd0, 2'd0, 1'b0, 3'd0,
                    11'h0D0, 10'h000, 2'd0, 32'h0D0572D7);
        tbl[2] = mk(2'd1, 7'h57, 3'd0, 5'd5, 5'd4, 5'd0, 1'b0, 6'h00, 3'd0, 2'd0, 1'b0, 3'd0,
                    11'h7FF, 10'h0D0, 2'd3, 32'hCD0272D7);
        tbl[3] = mk(2'd2, 7'h07, 3'd5, 5'd8, 5'd11, 5'd0, 1'b1, 6'h3F, 3'd6, 2'd0, 1'b0, 3'd0,
                    11'h7FF, 10'h3FF, 2'd3, 32'h0205E407);
        tbl[4] = mk(2'd1, 7'h57, 3'd0, 5'd3, 5'd4, 5'd5, 1'b1, 6'h00, 3'd0, 2'd0, 1'b0, 3'd0,
                    11'h7FF, 10'h3FF, 2'd2, 32'h805271D7);
        tbl[5] = mk(2'd0, 7'h57, 3'd3, 5'd31, 5'd0, 5'd31, 1'b0, 6'h3F, 3'd0, 2'd0, 1'b0, 3'd0,
                    11'h000, 10'h000, 2'd0, 32'hFDF03FD7);
        tbl[6] = mk(2'd2, 7'h27, 3'd0, 5'd4, 5'd2, 5'd1, 1'b0, 6'h00, 3'd7, 2'd3, 1'b1, 3'd7,
                    11'h000, 10'h000, 2'd0, 32'hFC117227);
        tbl[7] = mk(2'd1, 7'h57, 3'd2, 5'd0, 5'd0, 5'd31, 1'b1, 6'h3F, 3'd0, 2'd0, 1'b0, 3'd0,
                    11'h7FF, 10'h000, 2'd1, 32'h7FF07057);

        mon_en    = 1'b0;
        cnt_m     = '0;
        err_m     = 1'b0;
        err_seen  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(mk(2'd0, 7'h0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 6'h0, 3'd0, 2'd0, 1'b0, 3'd0,
                 11'h0, 10'h0, 2'd0, 32'h0));
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        rst    = 1'b0;

        // Table-driven encodings, drained one at a time so latency is visible.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i]);
            @(negedge clk);
            chk($sformatf("tbl%0d_word", i), insn_out, tbl[i].exp);
            wait_drain();
        end

        // Back-pressure: four fill the FIFO, the fifth stalls.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_req(2'($urandom_range(0, 2))));
        drive(rand_req(2'd0));
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        chk("bp_issued", 32'(issued_cnt), 32'd4);

        // Illegal request sandwiched between two legal ones.
        do_reset();
        err_seen = 0;
        send(rand_req(2'd0));
        send(rand_req(2'd3));
        send(rand_req(2'd2));
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("ill_err_pulses", 32'(err_seen), 32'd1);
        chk("ill_issued", 32'(issued_cnt), 32'd2);

        // Random streaming with random back-pressure and occasional illegal kinds.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(rand_req(2'($urandom_range(0, 3))));
        end
        out_ready = 1'b1;
        wait_drain();

        // Counter wrap: 17 issues on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) send(rand_req(2'($urandom_range(0, 2))));
        wait_drain();
        chk("wrap_issued", 32'(issued_cnt), 32'd1);

        // Reset with words queued and an err pulse pending.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_req(2'd1));
        send(rand_req(2'd3));
        @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_issued", 32'(issued_cnt), 32'd0);
        chk("rst_insn_out", insn_out, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
